// File: rtl/fft_reorder_buf_pkg.sv
// Shared definitions for the digit-reversal reorder buffer: default word width,
// configuration legality check, digit-reversal helper and FSM state encodings.
package fft_reorder_buf_pkg;

    localparam int NB_DEFAULT = 16;

    typedef enum logic {W_IDLE, W_FILL}  wstate_e;
    typedef enum logic {R_IDLE, R_DRAIN} rstate_e;

    function automatic bit drev_legal(input int log2n, input int rl);
        return (rl > 0) && (log2n > 0) && (log2n <= 30) && ((log2n % rl) == 0);
    endfunction

    // Reverse the order of base-2^rl digits of k; bits inside a digit keep their order.
    function automatic int drev(input int k, input int log2n, input int rl);
        int r;
        int nd;
        int d;
        r  = 0;
        nd = log2n / rl;
        for (int i = 0; i < 31; i++) begin
            if (i < log2n) begin
                d = i / rl;
                r = r | (((k >> i) & 1) << ((nd - 1 - d) * rl + (i % rl)));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_buf_if.sv
// Streaming sample interface of the reorder buffer; BYPASS exists only when
// FFT_REORDER_BYPASS_EN is defined.
interface fft_reorder_buf_if #(parameter int NB = 16);
    logic          START;
    logic [NB-1:0] DR;
    logic [NB-1:0] DI;
    logic [NB-1:0] OR;
    logic [NB-1:0] OI;
    logic          OSTART;
    logic          OVALID;
    logic          ERR_RESTART;
`ifdef FFT_REORDER_BYPASS_EN
    logic          BYPASS;

    modport slave  (input  START, DR, DI, BYPASS, output OR, OI, OSTART, OVALID, ERR_RESTART);
    modport master (output START, DR, DI, BYPASS, input  OR, OI, OSTART, OVALID, ERR_RESTART);
`else
    modport slave  (input  START, DR, DI, output OR, OI, OSTART, OVALID, ERR_RESTART);
    modport master (output START, DR, DI, input  OR, OI, OSTART, OVALID, ERR_RESTART);
`endif
endinterface

// File: rtl/fft_reorder_buf_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; address is {bank, index},
// read data is registered.
module reorder_bank_ram #(
    parameter int W  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [0:(1<<AW)-1];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong reorder buffer: digit-reversed frames in, natural-order frames out.
// Optional natural-order bypass per frame under FFT_REORDER_BYPASS_EN.
module fft_reorder_buf
    import fft_reorder_buf_pkg::*;
#(
    parameter int NB         = NB_DEFAULT,
    parameter int LOG2N      = 5,
    parameter int RADIX_LOG2 = 1
) (
    input  logic              CLK,
    input  logic              RST,
    fft_reorder_buf_if.slave  io
);
    localparam logic [LOG2N-1:0] LAST = '1;

    if (!drev_legal(LOG2N, RADIX_LOG2)) begin : g_bad_cfg
        $error("fft_reorder_buf: LOG2N must be a positive multiple of RADIX_LOG2");
    end

    wstate_e          wstate_q, wstate_d;
    rstate_e          rstate_q, rstate_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic             wsel_q, wsel_d;
    logic             ostart_q, ostart_d;
    logic             ovalid_q, ovalid_d;
    logic             err_q, err_d;
    logic             byp_fill_q, byp_fill_d;
    logic             byp_rd_q, byp_rd_d;
    logic             we;
    logic             fill_done;
    logic             byp_in;
    logic [LOG2N-1:0] ridx;
    logic [2*NB-1:0]  rdata;

`ifdef FFT_REORDER_BYPASS_EN
    assign byp_in = io.BYPASS;
`else
    assign byp_in = 1'b0;
`endif

    always_comb begin
        wstate_d   = wstate_q;
        rstate_d   = rstate_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        wsel_d     = wsel_q;
        byp_fill_d = byp_fill_q;
        byp_rd_d   = byp_rd_q;
        ostart_d   = 1'b0;
        err_d      = 1'b0;
        we         = 1'b0;
        fill_done  = 1'b0;

        case (wstate_q)
            W_IDLE: begin
                if (io.START) begin
                    wstate_d   = W_FILL;
                    wcnt_d     = '0;
                    byp_fill_d = byp_in;
                end
            end
            default: begin
                we = 1'b1;
                if (wcnt_q == LAST) begin
                    fill_done = 1'b1;
                    wsel_d    = ~wsel_q;
                    wcnt_d    = '0;
                    wstate_d  = io.START ? W_FILL : W_IDLE;
                    if (io.START) byp_fill_d = byp_in;
                end else if (io.START) begin
                    // Partial frame is dropped; refill the same bank from index 0.
                    wcnt_d     = '0;
                    err_d      = 1'b1;
                    byp_fill_d = byp_in;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
        endcase

        case (rstate_q)
            R_IDLE: begin
                if (fill_done) begin
                    rstate_d = R_DRAIN;
                    rcnt_d   = '0;
                    ostart_d = 1'b1;
                    byp_rd_d = byp_fill_q;
                end
            end
            default: begin
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == LAST) begin
                    if (fill_done) begin
                        ostart_d = 1'b1;
                        byp_rd_d = byp_fill_q;
                    end else begin
                        rstate_d = R_IDLE;
                    end
                end
            end
        endcase

        ovalid_d = (rstate_q == R_DRAIN);
        ridx     = byp_rd_q ? rcnt_q : LOG2N'(drev(int'(rcnt_q), LOG2N, RADIX_LOG2));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            wsel_q     <= 1'b0;
            ostart_q   <= 1'b0;
            ovalid_q   <= 1'b0;
            err_q      <= 1'b0;
            byp_fill_q <= 1'b0;
            byp_rd_q   <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            wsel_q     <= wsel_d;
            ostart_q   <= ostart_d;
            ovalid_q   <= ovalid_d;
            err_q      <= err_d;
            byp_fill_q <= byp_fill_d;
            byp_rd_q   <= byp_rd_d;
        end
    end

    reorder_bank_ram #(.W(2*NB), .AW(LOG2N+1)) u_ram (
        .clk   (CLK),
        .we    (we),
        .waddr ({wsel_q, wcnt_q}),
        .wdata ({io.DR, io.DI}),
        .raddr ({~wsel_q, ridx}),
        .rdata (rdata)
    );

    // RAM read register is not reset; gating on OVALID keeps idle/reset outputs at zero.
    assign io.OR          = ovalid_q ? rdata[2*NB-1:NB] : '0;
    assign io.OI          = ovalid_q ? rdata[NB-1:0]    : '0;
    assign io.OSTART      = ostart_q;
    assign io.OVALID      = ovalid_q;
    assign io.ERR_RESTART = err_q;
endmodule
